// File: rtl/fixed_to_fp_pkg.sv
// Shared constants, state encodings and the float word layout for the multi-cycle fp units.
package fixed_to_fp_pkg;

  localparam int unsigned FP_BIAS   = 127;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MANT_W = 23;
  localparam logic [31:0] FP_ZERO   = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ABS   = 3'd1;
  localparam logic [2:0] ST_ENC   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_PACK  = 3'd4;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/fixed_to_fp_if.sv
// Start/done request bus between a fixed-point producer and the float converter.
interface fixed_to_fp_if;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic [31:0] result;
  logic        done;

  modport master (output start, output data_in, input busy, input result, input done);
  modport slave  (input start, input data_in, output busy, output result, output done);
endinterface

// File: rtl/fixed_to_fp_priority_enc32.sv
// Index of the highest set bit of a 32-bit word; index is 0 and o_zero is set for a zero input.
module priority_enc32 (
  input  logic [31:0] i_data,
  output logic [4:0]  o_idx,
  output logic        o_zero
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_idx = 5'(i);
    end
  end

  assign o_zero = (i_data == '0);

endmodule

// File: rtl/fixed_to_fp.sv
// Five-state converter from signed Q(31-F).F fixed point to IEEE-754 single, truncating rounding.
module fixed_to_fp
  import fixed_to_fp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 0
) (
  input logic          clk,
  input logic          reset,
  fixed_to_fp_if.slave bus
);

  if (FRAC_BITS > 31) begin : g_bad_frac_bits
    $error("fixed_to_fp: FRAC_BITS must be in 0..31");
  end

  logic [2:0]  r_state;
  logic [31:0] r_mag;    // holds the raw operand in ABS, the magnitude afterwards
  logic        r_sign;
  logic        r_zero;
  logic [4:0]  r_p;
  logic [31:0] r_norm;
  logic [31:0] r_result;
  logic        r_done;

  logic [4:0]  w_p;
  logic        w_zero;
  logic [8:0]  w_exp;
  fp32_t       w_packed;
  logic        w_unused;

  priority_enc32 u_penc (
    .i_data (r_mag),
    .o_idx  (w_p),
    .o_zero (w_zero)
  );

  always_comb begin
    w_exp         = 9'(FP_BIAS) + {4'd0, r_p} - 9'(FRAC_BITS);
    w_packed.sign = r_sign;
    w_packed.exp  = w_exp[7:0];
    w_packed.mant = r_norm[30:8];
  end

  // Hidden one, truncated tail and exponent carry are dropped by design.
  assign w_unused = ^{r_norm[31], r_norm[7:0], w_exp[8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mag    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_p      <= '0;
      r_norm   <= '0;
      r_result <= FP_ZERO;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mag   <= bus.data_in;
            r_state <= ST_ABS;
          end
        end
        ST_ABS: begin
          r_sign  <= r_mag[31];
          r_mag   <= r_mag[31] ? -r_mag : r_mag;
          r_state <= ST_ENC;
        end
        ST_ENC: begin
          r_zero  <= w_zero;
          r_p     <= w_p;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_norm  <= r_mag << (5'd31 - r_p);
          r_state <= ST_PACK;
        end
        ST_PACK: begin
          r_result <= r_zero ? FP_ZERO : w_packed;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE) | r_done;
  assign bus.result = r_result;
  assign bus.done   = r_done;

endmodule
